// File: rtl/segment_combine_sched.sv
// Segment-combine scheduler: walks NUM_SEG segments of a job through one shared
// if/else combine datapath. For each segment it reads the operand pair from the
// operand RAM, holds the pair on the datapath inputs, waits DP_LAT cycles, captures
// the combine result, and offers it on a valid/ready result port.
module segment_combine_sched #(
    parameter int unsigned NUM_SEG = 8,
    parameter int unsigned SEG_W   = 3,
    parameter int unsigned DP_LAT  = 2,
    parameter int unsigned DW      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [DW-1:0]    input_bit,
    input  logic             abort,
    output logic             op_rd_en,
    output logic [SEG_W-1:0] seg_idx,
    input  logic [DW-1:0]    array_ref_wire,
    input  logic [DW-1:0]    array_ref_m_wire,
    output logic [DW-1:0]    dp_input_bit,
    output logic [DW-1:0]    dp_ref,
    output logic [DW-1:0]    dp_ref_m,
    input  logic [DW-1:0]    dp_combine,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DW-1:0]    res_data,
    output logic [SEG_W-1:0] res_seg,
    output logic             res_last,
    output logic             busy
);

    localparam int unsigned CNT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
    localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NUM_SEG - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_OUT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             last_q;

    // Status and strobes decoded directly from the state register.
    // Abort suppresses the result beat in the same cycle so a concurrent
    // res_ready can never complete a handshake.
    assign start_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign op_rd_en    = (state == S_FETCH);
    assign res_valid   = (state == S_OUT) && !abort;
    assign res_last    = res_valid && last_q;

    // Segment sequencer: state, segment index, datapath operand and result registers.
    // NOTE: every register here is assigned with <= so all of them sample the
    // pre-edge values of each other; the async reset clears them all at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            seg_idx      <= '0;
            wait_cnt     <= '0;
            last_q       <= 1'b0;
            dp_input_bit <= '0;
            dp_ref       <= '0;
            dp_ref_m     <= '0;
            res_data     <= '0;
            res_seg      <= '0;
        end else if (abort) begin
            state   <= S_IDLE;
            seg_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_valid) begin
                        dp_input_bit <= input_bit;
                        seg_idx      <= '0;
                        state        <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    // RAM data for seg_idx arrives this cycle; hold it through WAIT/OUT.
                    dp_ref   <= array_ref_wire;
                    dp_ref_m <= array_ref_m_wire;
                    wait_cnt <= CNT_W'(DP_LAT - 1);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        res_data <= dp_combine;
                        res_seg  <= seg_idx;
                        last_q   <= (seg_idx == LAST_SEG);
                        state    <= S_OUT;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        if (seg_idx == LAST_SEG) begin
                            seg_idx <= '0;
                            state   <= S_IDLE;
                        end else begin
                            seg_idx <= seg_idx + SEG_W'(1);
                            state   <= S_FETCH;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
